// File: rtl/enemy_tank_ctrl.sv
// enemy_tank_ctrl: one enemy tank. It spawns when enabled, drives forward
// on each slow tick, reverses at the playfield edges, turns at random every
// DIR_HOLD clear moves, dies on a hit and respawns after RESPAWN_TICKS ticks.
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   clk_4Hz                slow square wave (async to clk), one move per rise
//   tank_en                level enable from the tank generator
//   hit                    one-cycle bullet collision pulse
//   tank_x, tank_y         position
//   tank_dir               0 up, 1 down, 2 left, 3 right
//   tank_alive             drawn / collidable (state MOVE)
//   tank_destroyed         one-cycle pulse on kill
module enemy_tank_ctrl #(
  parameter logic [10:0] X_INIT        = 11'd64,
  parameter logic [10:0] Y_INIT        = 11'd32,
  parameter logic [10:0] X_MAX         = 11'd608,
  parameter logic [10:0] Y_MAX         = 11'd448,
  parameter logic [10:0] STEP          = 11'd4,
  parameter logic [3:0]  DIR_HOLD      = 4'd8,
  parameter logic [3:0]  RESPAWN_TICKS = 4'd8,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_4Hz,
  input  logic        tank_en,
  input  logic        hit,
  output logic [10:0] tank_x,
  output logic [10:0] tank_y,
  output logic [1:0]  tank_dir,
  output logic        tank_alive,
  output logic        tank_destroyed
);

  typedef enum logic [1:0] {IDLE, SPAWN, MOVE, DEAD} state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [1:0]  dir_q, dir_d;
  logic [3:0]  hold_q, hold_d, dead_q, dead_d;
  logic        destr_q, destr_d;
  logic        s1_q, s2_q, hist_q;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        tick, blocked;

  // Two-flop synchronizer plus history flop; tick is one clk cycle per rise.
  assign tick = s2_q & ~hist_q;

  // x^8+x^6+x^5+x^4+1, free-running in every state.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Edge test in 11-bit unsigned arithmetic.
  always_comb begin
    blocked = 1'b0;
    unique case (dir_q)
      2'd0: blocked = (y_q < STEP);
      2'd1: blocked = ((y_q + STEP) > Y_MAX);
      2'd2: blocked = (x_q < STEP);
      2'd3: blocked = ((x_q + STEP) > X_MAX);
      default: blocked = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    destr_d = 1'b0;
    unique case (state_q)
      IDLE: if (tank_en) state_d = SPAWN;
      SPAWN: begin
        x_d     = X_INIT;
        y_d     = Y_INIT;
        dir_d   = 2'd1;
        hold_d  = '0;
        dead_d  = '0;
        state_d = MOVE;
      end
      MOVE: begin
        // hit outranks both a falling enable and a same-cycle tick
        if (hit) begin
          state_d = DEAD;
          destr_d = 1'b1;
          dead_d  = '0;
        end else if (!tank_en) begin
          state_d = IDLE;
        end else if (tick) begin
          if (blocked) begin
            dir_d  = dir_q ^ 2'b01;
            hold_d = '0;
          end else begin
            unique case (dir_q)
              2'd0: y_d = y_q - STEP;
              2'd1: y_d = y_q + STEP;
              2'd2: x_d = x_q - STEP;
              2'd3: x_d = x_q + STEP;
              default: ;
            endcase
            if (hold_q == DIR_HOLD - 4'd1) begin
              dir_d  = lfsr_q[1:0];
              hold_d = '0;
            end else begin
              hold_d = hold_q + 4'd1;
            end
          end
        end
      end
      DEAD: begin
        // enable is only consulted once the full wait has elapsed
        if (tick) begin
          if (dead_q == RESPAWN_TICKS - 4'd1) begin
            dead_d  = '0;
            state_d = tank_en ? SPAWN : IDLE;
          end else begin
            dead_d = dead_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
      dir_q   <= 2'd1;
      hold_q  <= '0;
      dead_q  <= '0;
      destr_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      hist_q  <= 1'b0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      destr_q <= destr_d;
      s1_q    <= clk_4Hz;
      s2_q    <= s1_q;
      hist_q  <= s2_q;
      lfsr_q  <= lfsr_d;
    end
  end

  assign tank_x         = x_q;
  assign tank_y         = y_q;
  assign tank_dir       = dir_q;
  assign tank_alive     = (state_q == MOVE);
  assign tank_destroyed = destr_q;

endmodule

// File: tb/tb_enemy_tank_ctrl.sv
module tb_enemy_tank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clk_4Hz, tank_en, hit;
  logic [10:0] tank_x, tank_y, b_x, b_y;
  logic [1:0]  tank_dir, b_dir;
  logic        tank_alive, tank_destroyed, b_alive, b_destr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  enemy_tank_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clk_4Hz(clk_4Hz), .tank_en(tank_en), .hit(hit),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .tank_alive(tank_alive), .tank_destroyed(tank_destroyed)
  );

  // Second instance spawned near the bottom edge to exercise the blocked path.
  enemy_tank_ctrl #(.Y_INIT(11'd438)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_4Hz(clk_4Hz), .tank_en(tank_en), .hit(1'b0),
    .tank_x(b_x), .tank_y(b_y), .tank_dir(b_dir),
    .tank_alive(b_alive), .tank_destroyed(b_destr)
  );

  // Reference LFSR; m_prev holds the value that was current before the last edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  typedef struct {
    string       tag;
    logic [10:0] x, y;
    logic [1:0]  dir;
    logic        alive, destr, use_pos, use_dir;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [10:0] x, input logic [10:0] y,
                            input logic [1:0] dir, input logic alive, input logic destr,
                            input logic use_pos, input logic use_dir);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.dir = dir; e.alive = alive; e.destr = destr;
    e.use_pos = use_pos; e.use_dir = use_dir;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (e.use_pos) begin
        chk({e.tag, ".x"}, 32'(tank_x), 32'(e.x));
        chk({e.tag, ".y"}, 32'(tank_y), 32'(e.y));
      end
      if (e.use_dir) chk({e.tag, ".dir"}, 32'(tank_dir), 32'(e.dir));
      chk({e.tag, ".alive"}, 32'(tank_alive), 32'(e.alive));
      chk({e.tag, ".destroyed"}, 32'(tank_destroyed), 32'(e.destr));
    end
  endtask

  // Low for a few cycles, rise at a falling clk edge, then stop after the
  // 2nd rising clk edge (tick is high, its action not yet applied).
  task automatic tick_raise();
    @(negedge clk) clk_4Hz = 1'b0;
    repeat (3) @(negedge clk);
    clk_4Hz = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // 3rd rising edge: the tick's action is now visible.
  task automatic tick_fin();
    @(negedge clk);
  endtask

  task automatic do_tick();
    tick_raise();
    tick_fin();
  endtask

  initial begin
    rst_n = 1'b0; clk_4Hz = 1'b0; tank_en = 1'b1; hit = 1'b0;
    #12;
    expect_out("reset", 11'd64, 11'd32, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_out();

    // Spawn sequence: SPAWN after 1st edge, MOVE/alive after 2nd.
    @(negedge clk) rst_n = 1'b1;
    expect_out("spawn_e1", 11'd64, 11'd32, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk) check_out();
    expect_out("spawn_e2", 11'd64, 11'd32, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk) check_out();
    chk("b_spawn_y", 32'(b_y), 32'd438);

    // Three ticks down: check both just before and just after the 3rd edge.
    for (int k = 1; k <= 3; k++) begin
      expect_out($sformatf("tick%0d_pre", k), 11'd64, 11'(32 + 4*(k-1)), 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      expect_out($sformatf("tick%0d", k), 11'd64, 11'(32 + 4*k), 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick_raise();
      check_out();
      tick_fin();
      check_out();
      if (k == 1) chk("b_tick1_y", 32'(b_y), 32'd442);
      if (k == 2) chk("b_tick2_y", 32'(b_y), 32'd446);
      if (k == 3) begin
        chk("b_blocked_y", 32'(b_y), 32'd446);
        chk("b_blocked_dir", 32'(b_dir), 32'd0);
      end
    end

    // Ticks 4..7 keep moving down; tick 4 also moves dut_b back up.
    for (int k = 4; k <= 7; k++) begin
      expect_out($sformatf("tick%0d", k), 11'd64, 11'(32 + 4*k), 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      do_tick();
      check_out();
      if (k == 4) chk("b_reverse_y", 32'(b_y), 32'd442);
    end

    // 8th clear tick moves, then takes a random heading from the LFSR.
    do_tick();
    expect_out("tick8_turn", 11'd64, 11'd64, m_prev[1:0], 1'b1, 1'b0, 1'b1, 1'b1);
    check_out();

    // Kill in MOVE: one-cycle destroyed pulse.
    @(negedge clk) hit = 1'b1;
    expect_out("kill", 11'd0, 11'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk) hit = 1'b0;
    check_out();
    expect_out("kill_pulse_end", 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) check_out();
    // Hit while dead must not re-fire.
    hit = 1'b1;
    expect_out("hit_in_dead", 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) hit = 1'b0;
    check_out();

    repeat (7) do_tick();
    expect_out("dead_7ticks", 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    do_tick();
    expect_out("respawn", 11'd64, 11'd32, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk) check_out();

    // Hit and enable drop together: hit wins, then return to IDLE.
    @(negedge clk) begin hit = 1'b1; tank_en = 1'b0; end
    expect_out("kill_en_low", 11'd64, 11'd32, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk) hit = 1'b0;
    check_out();
    expect_out("kill_en_low_end", 11'd64, 11'd32, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk) check_out();
    repeat (8) do_tick();
    repeat (3) @(negedge clk);
    expect_out("idle_after_dead", 11'd64, 11'd32, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_out();

    // Re-enable from IDLE, move twice, then drop enable without a hit.
    tank_en = 1'b1;
    repeat (2) @(negedge clk);
    expect_out("reenable", 11'd64, 11'd32, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_out();
    repeat (2) do_tick();
    expect_out("reenable_move", 11'd64, 11'd40, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_out();
    tank_en = 1'b0;
    expect_out("disable", 11'd64, 11'd40, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk) check_out();

    // Respawn then asynchronous reset mid-MOVE.
    tank_en = 1'b1;
    repeat (3) @(negedge clk);
    do_tick();
    expect_out("pre_reset", 11'd64, 11'd36, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_out();
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 11'd64, 11'd32, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_out();
    chk("reset_b_y", 32'(b_y), 32'd438);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_out("post_reset_spawn", 11'd64, 11'd32, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
